boolean_sweep_tester: RTL

//   Exhaustive self-test stage wrapped around the combinational two-function

---
 rtl/boolean_pkg.sv | 36 +++
 rtl/boolean_sweep_tester.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/boolean_pkg.sv
// ---------------------------------------------------------------------------
// boolean_pkg
//   Shared constants for the boolean sweep tester: FSM state encoding,
//   sweep geometry and the golden truth tables of the two-function block.
//   F1 is a function of {A,B,C,D} and F2 of {w,x,y,z}. In both golden
//   tables, bit v holds the function value for input vector v.
// ---------------------------------------------------------------------------
package boolean_pkg;

    // FSM state encoding. Plain 2-bit constants keep the encoding visible
    // to tools and waveform viewers that do not decode enums.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Sweep geometry: every 4-bit vector is visited exactly once.
    localparam int         NUM_VEC  = 16;
    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

    // Golden truth tables of the function block.
    localparam logic [15:0] EXP_F1_DEFAULT = 16'h35A5;
    localparam logic [15:0] EXP_F2_DEFAULT = 16'hF2E2;

    // The sweep passes only if both captured tables match their golden
    // tables exactly.
    function automatic logic tables_match(
        input logic [15:0] tt_a,
        input logic [15:0] tt_b,
        input logic [15:0] exp_a,
        input logic [15:0] exp_b
    );
        return (tt_a == exp_a) && (tt_b == exp_b);
    endfunction

endpackage : boolean_pkg

// File: rtl/boolean_sweep_tester.sv
// ---------------------------------------------------------------------------
// boolean_sweep_tester
//   Exhaustive self-test stage for the combinational two-function block.
//   A start pulse makes the block apply all 16 input vectors to both input
//   sets. Each vector is held for SETTLE_CYCLES cycles, and F1 and F2 are
//   then sampled. The sampled bits build two truth tables and two minterm
//   counts. At the end of the sweep the tables are compared with the golden
//   values, and done is pulsed for one cycle.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   EXP_F1         golden F1 table, bit v = F1({A,B,C,D}=v)
//   EXP_F2         golden F2 table, bit v = F2({w,x,y,z}=v)
//
// Ports
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   start         in   1   pulse; begins a sweep when the block is idle
//   abort         in   1   stops an active sweep (ignored in DONE)
//   f1_in         in   1   F1 from the function block
//   f2_in         in   1   F2 from the function block
//   drv_abcd      out  4   {A,B,C,D} drive, A = MSB
//   drv_wxyz      out  4   {w,x,y,z} drive, w = MSB (same as drv_abcd)
//   busy          out  1   sweep in progress
//   done          out  1   one-cycle pulse when a sweep completes
//   result_valid  out  1   result outputs hold a complete sweep
//   tt_f1         out  16  captured F1 truth table
//   tt_f2         out  16  captured F2 truth table
//   ones_f1       out  5   number of ones in tt_f1 (0..16)
//   ones_f2       out  5   number of ones in tt_f2 (0..16)
//   pass          out  1   both tables match; meaningful with result_valid
// ---------------------------------------------------------------------------
module boolean_sweep_tester
    import boolean_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] EXP_F1        = EXP_F1_DEFAULT,
    parameter logic [15:0] EXP_F2        = EXP_F2_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f1_in,
    input  logic        f2_in,
    output logic [3:0]  drv_abcd,
    output logic [3:0]  drv_wxyz,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [15:0] tt_f1,
    output logic [15:0] tt_f2,
    output logic [4:0]  ones_f1,
    output logic [4:0]  ones_f2,
    output logic        pass
);

    // The settle counter only has to reach SETTLE_CYCLES-1, so
    // clog2(SETTLE_CYCLES) bits are enough. At least one bit is kept.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q,        state_d;
    logic [3:0]       vec_q,          vec_d;
    logic [CNT_W-1:0] settle_cnt_q,   settle_cnt_d;
    logic             busy_q,         busy_d;
    logic             done_q,         done_d;
    logic             result_valid_q, result_valid_d;
    logic [15:0]      tt_f1_q,        tt_f1_d;
    logic [15:0]      tt_f2_q,        tt_f2_d;
    logic [4:0]       ones_f1_q,      ones_f1_d;
    logic [4:0]       ones_f2_q,      ones_f2_d;
    logic             pass_q,         pass_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here first gets a default (hold its value,
        // or 0 for the done pulse). Without these defaults, a path through the
        // case that misses an assignment would infer a latch.
        state_d        = state_q;
        vec_d          = vec_q;
        settle_cnt_d   = settle_cnt_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_valid_d = result_valid_q;
        tt_f1_d        = tt_f1_q;
        tt_f2_d        = tt_f2_q;
        ones_f1_d      = ones_f1_q;
        ones_f2_d      = ones_f2_q;
        pass_d         = pass_q;

        case (state_q)
            ST_IDLE: begin
                // abort has priority over start, so nothing starts when
                // both are high.
                if (start && !abort) begin
                    vec_d          = 4'd0;
                    settle_cnt_d   = '0;
                    tt_f1_d        = 16'd0;
                    tt_f2_d        = 16'd0;
                    ones_f1_d      = 5'd0;
                    ones_f2_d      = 5'd0;
                    pass_d         = 1'b0;
                    result_valid_d = 1'b0;
                    busy_d         = 1'b1;
                    state_d        = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    vec_d        = 4'd0;
                    settle_cnt_d = '0;
                end else begin
                    // The counter may step past SETTLE_LAST on the exit
                    // cycle. That is harmless, because it is cleared
                    // before it is used again.
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    // The partial tables are left in place. result_valid
                    // stays low, so they are not presented as a result.
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    vec_d        = 4'd0;
                    settle_cnt_d = '0;
                end else begin
                    tt_f1_d[vec_q] = f1_in;
                    tt_f2_d[vec_q] = f2_in;
                    ones_f1_d      = ones_f1_q + 5'(f1_in);
                    ones_f2_d      = ones_f2_q + 5'(f2_in);
                    // The sweep stops at the last vector instead of
                    // letting vec wrap back to 0.
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d        = vec_q + 4'd1;
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                // abort is ignored here. The last vector is already
                // captured, so the sweep is allowed to complete.
                done_d         = 1'b1;
                busy_d         = 1'b0;
                result_valid_d = 1'b1;
                pass_d         = tables_match(tt_f1_q, tt_f2_q, EXP_F1, EXP_F2);
                vec_d          = 4'd0;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                vec_d   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: the truth tables are only 32 flops. They are reset together with
    // the rest of the state, so every output reads 0 right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            vec_q          <= 4'd0;
            settle_cnt_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            tt_f1_q        <= 16'd0;
            tt_f2_q        <= 16'd0;
            ones_f1_q      <= 5'd0;
            ones_f2_q      <= 5'd0;
            pass_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values it had before the edge, whatever the statement order.
            state_q        <= state_d;
            vec_q          <= vec_d;
            settle_cnt_q   <= settle_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            tt_f1_q        <= tt_f1_d;
            tt_f2_q        <= tt_f2_d;
            ones_f1_q      <= ones_f1_d;
            ones_f2_q      <= ones_f2_d;
            pass_q         <= pass_d;
        end
    end

    // Both input sets are driven from the same vector register.
    assign drv_abcd     = vec_q;
    assign drv_wxyz     = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign tt_f1        = tt_f1_q;
    assign tt_f2        = tt_f2_q;
    assign ones_f1      = ones_f1_q;
    assign ones_f2      = ones_f2_q;
    assign pass         = pass_q;

endmodule : boolean_sweep_tester
